mmc_quad_scheduler: RTL

Sequencer for the 32x32 8-bit matrix-multiply engine with four computation units (CUs), computing C = A x B.
- Issues reads to the A SRAM (one byte per address) and the B SRAM (one 32-bit word = four adjacent B columns).
- Drives the shared MAC clear/enable strobes for the four CUs.
- Drains the four accumulated 21-bit results to the C sink through a valid/ready handshake.
- Sits between the top-level start/done interface and the SRAMs/CU array.

---
 rtl/mmc_pkg.sv | 12 +
 rtl/mmc_quad_scheduler_if.sv | 24 ++
 rtl/mmc_loop_nest.sv | 40 ++++
 rtl/mmc_quad_scheduler.sv | 83 ++++++++
 4 files changed

// File: rtl/mmc_pkg.sv
// mmc_pkg: shared dimensions and FSM states for the quad-CU matrix-multiply scheduler.
package mmc_pkg;
    localparam int N      = 32;
    localparam int LANES  = 4;
    localparam int AW_A   = 10;
    localparam int AW_B   = 8;
    localparam int GROUPS = N / LANES;
    localparam int IW     = $clog2(N);
    localparam int GW     = $clog2(GROUPS);
    localparam int UW     = $clog2(LANES);
    typedef enum logic [2:0] {IDLE, FETCH, FLUSH, WRITE, DONE} state_t;
endpackage

// File: rtl/mmc_quad_scheduler_if.sv
// mmc_quad_scheduler_if: start/done control, SRAM read, MAC strobe and C-sink handshake bundle.
interface mmc_quad_scheduler_if;
    import mmc_pkg::*;
    logic            start;
    logic            c_ready;
    logic            nce;
    logic [AW_A-1:0] addr_a;
    logic [AW_B-1:0] addr_b;
    logic            mac_en;
    logic            mac_clr;
    logic            c_valid;
    logic [UW-1:0]   unit_sel;
    logic [AW_A-1:0] addr_c;
    logic            busy;
    logic            done;
    modport master (
        input  start, c_ready,
        output nce, addr_a, addr_b, mac_en, mac_clr, c_valid, unit_sel, addr_c, busy, done
    );
    modport slave (
        output start, c_ready,
        input  nce, addr_a, addr_b, mac_en, mac_clr, c_valid, unit_sel, addr_c, busy, done
    );
endinterface

// File: rtl/mmc_loop_nest.sv
// mmc_loop_nest: i (row) / jg (column group) / k (inner) counters for the tile loop.
module mmc_loop_nest
    import mmc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          step_k_i,
    input  logic          step_tile_i,
    input  logic          clear_i,
    output logic          last_k_o,
    output logic          last_tile_o,
    output logic [IW-1:0] i_o,
    output logic [GW-1:0] jg_o,
    output logic [IW-1:0] k_o
);
    logic [IW-1:0] i_q, k_q;
    logic [GW-1:0] jg_q;
    logic          jg_last;

    assign jg_last     = jg_q == GW'(GROUPS - 1);
    assign last_k_o    = k_q == IW'(N - 1);
    assign last_tile_o = jg_last && i_q == IW'(N - 1);
    assign i_o         = i_q;
    assign jg_o        = jg_q;
    assign k_o         = k_q;

    always_ff @(posedge clk) begin
        if (!rst || clear_i) begin
            i_q  <= '0;
            jg_q <= '0;
            k_q  <= '0;
        end else if (step_tile_i) begin
            k_q  <= '0;
            jg_q <= jg_last ? '0 : jg_q + 1'b1;
            i_q  <= jg_last ? i_q + 1'b1 : i_q;
        end else if (step_k_i) begin
            k_q  <= k_q + 1'b1;
        end
    end
endmodule

// File: rtl/mmc_quad_scheduler.sv
// mmc_quad_scheduler: sequences A/B SRAM reads, MAC strobes and result drain for C = A x B.
module mmc_quad_scheduler
    import mmc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    mmc_quad_scheduler_if.master bus
);
    state_t        state_q, state_d;
    logic [UW-1:0] unit_sel_q, unit_sel_d;
    logic          mac_en_q, mac_clr_q;
    logic          step_k, step_tile, clear, last_k, last_tile;
    logic [IW-1:0] i, k;
    logic [GW-1:0] jg;

    mmc_loop_nest u_loop (
        .clk(clk), .rst(rst),
        .step_k_i(step_k), .step_tile_i(step_tile), .clear_i(clear),
        .last_k_o(last_k), .last_tile_o(last_tile),
        .i_o(i), .jg_o(jg), .k_o(k)
    );

    // MAC strobes trail the read by the one-cycle SRAM latency
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            unit_sel_q <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_sel_q <= unit_sel_d;
            mac_en_q   <= state_q == FETCH;
            mac_clr_q  <= state_q == FETCH && k == '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        unit_sel_d = unit_sel_q;
        step_k     = 1'b0;
        step_tile  = 1'b0;
        clear      = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = bus.start ? FETCH : IDLE;
                clear   = bus.start;
            end
            FETCH: begin
                state_d = last_k ? FLUSH : FETCH;
                step_k  = !last_k;
            end
            FLUSH: begin
                state_d    = WRITE;
                unit_sel_d = '0;
            end
            WRITE: begin
                unit_sel_d = bus.c_ready ? unit_sel_q + 1'b1 : unit_sel_q;
                if (bus.c_ready && unit_sel_q == UW'(LANES - 1)) begin
                    state_d   = last_tile ? DONE : FETCH;
                    step_tile = !last_tile;
                end
            end
            DONE: begin
                state_d    = IDLE;
                clear      = 1'b1;
                unit_sel_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.nce      = state_q != FETCH;
    assign bus.addr_a   = AW_A'(int'(i) * N + int'(k));
    assign bus.addr_b   = AW_B'(int'(k) * GROUPS + int'(jg));
    assign bus.addr_c   = AW_A'(int'(i) * N + int'(jg) * LANES + int'(unit_sel_q));
    assign bus.mac_en   = mac_en_q;
    assign bus.mac_clr  = mac_clr_q;
    assign bus.c_valid  = state_q == WRITE;
    assign bus.unit_sel = unit_sel_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.done     = state_q == DONE;
endmodule
